shift_unit: RTL
===============

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; legal values are powers of two from 8 to 64.
REQ-002 The module SHALL have parameter STEP, default 1, giving the maximum shift distance per cycle; legal values are powers of two from 1 to WIDTH.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The module SHALL have port op, input, 2 bits: operation select; 00 SLL, 01 SRL, 10 SRA, 11 ROR (see REQ-026/027).
REQ-007 The module SHALL have port a, input, WIDTH bits: operand.
REQ-008 The module SHALL have port shamt, input, log2(WIDTH) bits: shift amount, unsigned.
REQ-009 The module SHALL have port busy, output, 1 bit: operation in progress; start ignored.
REQ-010 The module SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 The module SHALL have port result, output, WIDTH bits: last completed result.

Function
REQ-012 The module SHALL implement states IDLE, SHIFT and DONE; busy SHALL be 1 exactly in SHIFT and DONE, and done SHALL be 1 exactly in DONE.
REQ-013 In IDLE with start=1 at a rising edge, the module SHALL capture a, op and shamt, and enter SHIFT if shamt!=0, else DONE.
REQ-014 In SHIFT, on each edge the module SHALL shift the working value by min(STEP, remaining) bits and decrement remaining by the same amount.
REQ-015 The module SHALL go from SHIFT to DONE on the edge at which remaining reaches 0.
REQ-016 The module SHALL go from DONE to IDLE unconditionally on the next edge, and start sampled in DONE SHALL be ignored.
REQ-017 Latency SHALL be L = 1 + ceil(shamt/STEP) edges from the start-sampling edge to done rising; shamt=0 SHALL give L=1.
REQ-018 SLL and SRL SHALL fill vacated bits with 0; SRA SHALL fill them with captured a[WIDTH-1].
REQ-019 The result SHALL be updated with the final value on the edge entering DONE and held until the next edge entering DONE.
REQ-020 start asserted while busy=1 SHALL have no effect; input changes after the capture edge SHALL NOT affect the result.
REQ-021 The result SHALL equal the single-cycle RISC-V reference (a << shamt, a >> shamt, $signed(a) >>> shamt) for every legal shamt, including WIDTH-1.

Reset
REQ-022 While rst=0, the module SHALL asynchronously force state=IDLE, busy=0, done=0, result=0 and clear all internal working registers.
REQ-023 Reset asserted mid-operation SHALL abort it with no done pulse, and the first start after rst returns to 1 SHALL be accepted normally.
REQ-024 The module SHALL accept a start sampled on the first rising edge after reset deassertion.

Configuration
REQ-025 The module SHALL be controlled by macro SHIFT_UNIT_ROTATE_EN, which enables rotate support.
REQ-026 With SHIFT_UNIT_ROTATE_EN defined, op=11 SHALL perform rotate-right (ROR): bits leaving bit 0 re-enter at bit WIDTH-1, with the same latency rule.
REQ-027 Without SHIFT_UNIT_ROTATE_EN, op=11 SHALL behave exactly as SRL and no rotate logic SHALL be synthesised.

Verification
REQ-028 The bench SHALL cover: WIDTH=32, STEP=1, SRL, a=0x000000f0, shamt=4 -> result=0x0000000f, done 5 edges after start, busy high for 5 cycles.
REQ-029 The bench SHALL cover: WIDTH=32, STEP=4, SRA, a=0x80000000, shamt=31 -> result=0xffffffff, L=9; SRL with the same inputs -> 0x00000001.
REQ-030 The bench SHALL cover: SLL, a=0x12345678, shamt=0 -> result=0x12345678, done on the first edge after start; then SLL, shamt=4 with STEP=1 -> 0x23456780.
REQ-031 The bench SHALL cover: start SRL a=0xf0, shamt=8, STEP=1; pulse start with a=0xff, shamt=1 at cycle 3 -> ignored, final result=0x00000000, done exactly once.
REQ-032 The bench SHALL cover: start SLL a=1, shamt=20; assert rst at cycle 5 -> busy=0, done=0, result=0 immediately with no done pulse; a new start SRL a=0xf0, shamt=4 -> 0x0f.
REQ-033 The bench SHALL cover: with SHIFT_UNIT_ROTATE_EN, ROR a=0x000000f1, shamt=4 -> 0x1000000f; without the macro, same stimulus -> 0x0000000f.

Source files
------------

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle shifter (SLL/SRL/SRA, optional ROR) that moves the
// operand by at most STEP bit positions per clock.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN enables op=11 as rotate-right;
// without it op=11 behaves as SRL and no rotate path is built.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result
);

    localparam int SW = $clog2(WIDTH);
    // One extra bit so STEP == WIDTH is representable.
    localparam logic [SW:0] STEP_V = (SW+1)'(STEP);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_UNIT_ROTATE_EN
    localparam logic [1:0] OP_ROR  = 2'b11;
    localparam logic [SW:0] WIDTH_V = (SW+1)'(WIDTH);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] work_q;
    logic [SW-1:0]    remain_q;
    logic [1:0]       op_q;

    logic [SW:0]      remain_ext;
    logic [SW:0]      step_amt;
    logic [SW:0]      remain_left;
    logic [WIDTH-1:0] work_nxt;

    // One partial shift of n positions; SRA keeps the MSB, which still holds the
    // captured sign bit because every earlier partial shift preserved it.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic [1:0]       o,
        input logic [SW:0]      n
    );
        logic [WIDTH-1:0] r;
        case (o)
            OP_SLL:  r = v << n;
            OP_SRA:  r = $unsigned($signed(v) >>> n);
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR:  r = (v >> n) | (v << (WIDTH_V - n));
`endif
            default: r = v >> n;
        endcase
        return r;
    endfunction

    // Per-cycle distance is min(STEP, remaining).
    assign remain_ext  = {1'b0, remain_q};
    assign step_amt    = (remain_ext > STEP_V) ? STEP_V : remain_ext;
    assign remain_left = remain_ext - step_amt;
    assign work_nxt    = shift_step(work_q, op_q, step_amt);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; busy/done decode straight from state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (remain_left == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture on accept, step the working value, publish result entering DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_q   <= '0;
            remain_q <= '0;
            op_q     <= '0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work_q   <= a;
                        remain_q <= shamt;
                        op_q     <= op;
                        if (shamt == '0) begin
                            result <= a;
                        end
                    end
                end
                SHIFT: begin
                    work_q   <= work_nxt;
                    remain_q <= remain_left[SW-1:0];
                    if (remain_left == '0) begin
                        result <= work_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
